// File: rtl/sync_debounce.sv
// Synchronise a raw async level into clk and accept a new level only after DEBOUNCE
// consecutive en-ticks of stable mismatch. q changes SYNC_STAGES+1+DEBOUNCE edges after din.
// No backpressure; rise/fall are single-cycle pulses. Define SYNC_DEBOUNCE_GLITCH_CNT_EN for the rejection counter.
module sync_debounce #(
    parameter int   SYNC_STAGES = 2,
    parameter int   CNT_W       = 8,
    parameter int   DEBOUNCE    = 16,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       din,
    input  logic       en,
    output logic       q,
    output logic       rise,
    output logic       fall,
    output logic       busy
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    ,
    input  logic       clr_glitch,
    output logic [7:0] glitch_cnt
`endif
);

    // Reject configurations the counter or synchroniser cannot represent.
    if (DEBOUNCE < 1 || DEBOUNCE > (2 ** CNT_W) - 1 || SYNC_STAGES < 2) begin : g_bad_param
        $error("sync_debounce: illegal DEBOUNCE/CNT_W/SYNC_STAGES combination");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   q_q, q_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   busy_q, busy_d;
    logic                   s;
    logic                   reject;

    // Shift din through the synchroniser; only the last stage is ever observed.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Next-state logic: mismatch opens a CHECK window, en-ticks count it down, any match aborts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        reject  = 1'b0;
        unique case (state_q)
            STABLE: begin
                cnt_d = '0;
                if (s != q_q) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (s == q_q) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                    reject  = 1'b1;
                end else if (en) begin
                    // Bound is checked before incrementing so the counter never wraps.
                    if (cnt_q == CNT_LAST) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                        q_d     = s;
                        rise_d  = s;
                        fall_d  = ~s;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == CHECK);
    end

    // All state and outputs are registered; reset returns everything to a quiet STABLE.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync_q  <= {SYNC_STAGES{RESET_VAL}};
            state_q <= STABLE;
            cnt_q   <= '0;
            q_q     <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    assign q    = q_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = busy_q;

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt_q, glitch_cnt_d;

    // Saturating count of rejected glitches; clear takes priority over a same-cycle rejection.
    always_comb begin
        glitch_cnt_d = glitch_cnt_q;
        if (clr_glitch) begin
            glitch_cnt_d = '0;
        end else if (reject && glitch_cnt_q != 8'hFF) begin
            glitch_cnt_d = glitch_cnt_q + 8'd1;
        end
    end

    // Rejection counter register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            glitch_cnt_q <= '0;
        end else begin
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign glitch_cnt = glitch_cnt_q;
`else
    logic unused_reject;
    assign unused_reject = reject;
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// Directed bench for sync_debounce with DEBOUNCE=4, SYNC_STAGES=2.
// Each scenario task drives stimulus and compares outputs one time unit after the rising edge.
// Glitch counter checks are included only when SYNC_DEBOUNCE_GLITCH_CNT_EN is defined.
module tb_sync_debounce;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       din = 1'b0;
    logic       en = 1'b1;
    logic       q, rise, fall, busy;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    logic       clr_glitch = 1'b0;
    logic [7:0] glitch_cnt;
`endif

    int checks = 0;
    int errors = 0;

    sync_debounce #(
        .SYNC_STAGES(2),
        .CNT_W      (8),
        .DEBOUNCE   (4),
        .RESET_VAL  (1'b0)
    ) dut (
        .clk       (clk),
        .nreset    (nreset),
        .din       (din),
        .en        (en),
        .q         (q),
        .rise      (rise),
        .fall      (fall),
        .busy      (busy)
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        ,
        .clr_glitch(clr_glitch),
        .glitch_cnt(glitch_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        din    = 1'b0;
        en     = 1'b1;
        #2;
        for (int i = 0; i < 6; i++) begin
            din = ~din;
            step();
            checks++;
            if ({q, rise, fall, busy} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_hold[%0d]: q/rise/fall/busy=%b expected 0000", i, {q, rise, fall, busy});
            end
        end
        din = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if ({q, rise, fall, busy} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_release[%0d]: q/rise/fall/busy=%b expected 0000", k, {q, rise, fall, busy});
            end
        end
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        checks++;
        if (glitch_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_glitch_cnt: glitch_cnt=%0d expected 0", glitch_cnt);
        end
`endif
    endtask

    task automatic test_glitch_reject();
        logic exp_busy;
        for (int k = 1; k <= 10; k++) begin
            din = (k <= 3);
            step();
            exp_busy = (k >= 3 && k <= 5);
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL glitch_busy[%0d]: busy=%b expected %b", k, busy, exp_busy);
            end
            checks++;
            if ({q, rise, fall} !== 3'b000) begin
                errors++;
                $display("FAIL glitch_q[%0d]: q/rise/fall=%b expected 000", k, {q, rise, fall});
            end
        end
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        checks++;
        if (glitch_cnt !== 8'd1) begin
            errors++;
            $display("FAIL glitch_cnt_one: glitch_cnt=%0d expected 1", glitch_cnt);
        end
`endif
    endtask

    task automatic test_clean_rise();
        logic exp_busy, exp_q, exp_rise;
        din = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            exp_busy = (k >= 3 && k <= 6);
            exp_q    = (k >= 7);
            exp_rise = (k == 7);
            checks++;
            if ({q, rise, fall, busy} !== {exp_q, exp_rise, 1'b0, exp_busy}) begin
                errors++;
                $display("FAIL clean_rise[%0d]: q/rise/fall/busy=%b expected %b", k,
                         {q, rise, fall, busy}, {exp_q, exp_rise, 1'b0, exp_busy});
            end
        end
    endtask

    task automatic test_tick_gating();
        logic exp_busy, exp_q, exp_fall;
        int   fall_count;
        fall_count = 0;
        din = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            en = (k % 4 == 0);
            step();
            if (fall) fall_count++;
            exp_q    = (k < 16);
            exp_fall = (k == 16);
            exp_busy = (k >= 3 && k <= 15);
            checks++;
            if ({q, rise, fall, busy} !== {exp_q, 1'b0, exp_fall, exp_busy}) begin
                errors++;
                $display("FAIL tick_gating[%0d]: q/rise/fall/busy=%b expected %b", k,
                         {q, rise, fall, busy}, {exp_q, 1'b0, exp_fall, exp_busy});
            end
        end
        en = 1'b1;
        checks++;
        if (fall_count !== 1) begin
            errors++;
            $display("FAIL tick_fall_count: fall pulses=%0d expected 1", fall_count);
        end
    endtask

    task automatic test_reset_mid_check();
        logic exp_q, exp_rise;
        din = 1'b1;
        for (int k = 1; k <= 5; k++) step();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midchk_pre_busy: busy=%b expected 1", busy);
        end
        nreset = 1'b0;
        #1;
        checks++;
        if ({q, rise, fall, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL midchk_abort: q/rise/fall/busy=%b expected 0000", {q, rise, fall, busy});
        end
        step();
        @(negedge clk);
        nreset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_q    = (k >= 7);
            exp_rise = (k == 7);
            checks++;
            if ({q, rise, fall} !== {exp_q, exp_rise, 1'b0}) begin
                errors++;
                $display("FAIL midchk_rerise[%0d]: q/rise/fall=%b expected %b", k,
                         {q, rise, fall}, {exp_q, exp_rise, 1'b0});
            end
        end
        // q is now high: reset must force it back low with no fall pulse.
        nreset = 1'b0;
        #1;
        checks++;
        if ({q, rise, fall, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_from_high: q/rise/fall/busy=%b expected 0000", {q, rise, fall, busy});
        end
        din = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++;
            if ({q, rise, fall, busy} !== 4'b0000) begin
                errors++;
                $display("FAIL post_reset_quiet[%0d]: q/rise/fall/busy=%b expected 0000", k, {q, rise, fall, busy});
            end
        end
    endtask

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    task automatic test_glitch_saturation();
        checks++;
        if (glitch_cnt !== 8'd0) begin
            errors++;
            $display("FAIL sat_start: glitch_cnt=%0d expected 0", glitch_cnt);
        end
        for (int g = 0; g < 300; g++) begin
            for (int k = 1; k <= 6; k++) begin
                din = (k <= 3);
                step();
            end
        end
        checks++;
        if (glitch_cnt !== 8'd255) begin
            errors++;
            $display("FAIL sat_255: glitch_cnt=%0d expected 255", glitch_cnt);
        end
        // Clear lands on the same edge as a rejection.
        for (int k = 1; k <= 6; k++) begin
            din        = (k <= 3);
            clr_glitch = (k == 6);
            step();
        end
        clr_glitch = 1'b0;
        checks++;
        if (glitch_cnt !== 8'd0) begin
            errors++;
            $display("FAIL clr_wins: glitch_cnt=%0d expected 0", glitch_cnt);
        end
        for (int k = 1; k <= 6; k++) begin
            din = (k <= 3);
            step();
        end
        checks++;
        if (glitch_cnt !== 8'd1) begin
            errors++;
            $display("FAIL after_clr: glitch_cnt=%0d expected 1", glitch_cnt);
        end
        checks++;
        if (q !== 1'b0) begin
            errors++;
            $display("FAIL sat_q: q=%b expected 0", q);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_glitch_reject();
        test_clean_rise();
        test_tick_gating();
        test_reset_mid_check();
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        test_glitch_saturation();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_debounce.md
Name: sync_debounce

Overview:
Input conditioner that sits directly upstream of the single-bit reset-able register stage. It takes a raw asynchronous level (push-button, switch, external strobe), synchronises it into the clk domain, and rejects glitches shorter than a programmable number of sample ticks. It produces a clean level q, suitable as that register's d input, plus one-cycle rise/fall pulses for downstream control logic.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops (legal range 2..4)
CNT_W, 8, width of the debounce counter
DEBOUNCE, 16, consecutive qualifying ticks of a stable mismatch required to accept a new level (1 .. 2^CNT_W-1)
RESET_VAL, 0, value loaded into q and every synchroniser flop on reset

Ports:
clk  input  1  clock, rising edge
nreset  input  1  asynchronous, active-low reset
din  input  1  raw asynchronous input level
en  input  1  sample tick; the debounce counter advances only on cycles with en=1 (tie high for per-clock debounce)
q  output  1  debounced, synchronised level
rise  output  1  one-cycle pulse, high in the cycle q goes 0->1
fall  output  1  one-cycle pulse, high in the cycle q goes 1->0
busy  output  1  high while the FSM is in CHECK

Behaviour:
- Reset: nreset is asynchronous and active-low; clock is clk. While nreset=0:
  - q=RESET_VAL and all synchroniser flops=RESET_VAL.
  - rise=0, fall=0, busy=0, counter=0, state=STABLE.
  - Releasing reset never generates a rise or fall pulse.
- Synchroniser: a chain of SYNC_STAGES flops. Its last stage, s, is the only signal the FSM looks at; din is never used directly.
- FSM states: STABLE, CHECK.
  - STABLE, s==q: stay; counter held at 0.
  - STABLE, s!=q: go to CHECK, counter=0. Ignores en.
  - CHECK, s==q: glitch rejected. Go to STABLE, counter=0, q unchanged, no pulse.
  - CHECK, s!=q, en=0: hold state and counter.
  - CHECK, s!=q, en=1, counter<DEBOUNCE-1: counter+1.
  - CHECK, s!=q, en=1, counter==DEBOUNCE-1: commit. q<=s, counter<=0, go to STABLE.
- Pulses and busy:
  - rise/fall are registered and asserted for exactly one clk in the same cycle q takes its new value; never both high.
  - busy is registered: busy=1 exactly while state==CHECK.
- Latency (en=1 throughout, din stepping before clk edge 1): q changes after edge SYNC_STAGES+1+DEBOUNCE. With defaults that is edge 19.
- Glitch width: any s mismatch that lasts fewer than DEBOUNCE en-ticks in CHECK is fully rejected.
- Counter never wraps; the DEBOUNCE bound is checked before incrementing.
- Reset mid-CHECK aborts immediately. q returns to RESET_VAL with no pulse, even if q had already toggled away from RESET_VAL.
- Elaboration error if DEBOUNCE<1, DEBOUNCE>2^CNT_W-1, or SYNC_STAGES<2.

Optional Feature:
Macro SYNC_DEBOUNCE_GLITCH_CNT_EN.
- Defined: adds
  - input clr_glitch (1 bit)
  - output glitch_cnt (8 bits)
  glitch_cnt increments on every CHECK->STABLE rejection and saturates at 255. clr_glitch=1 sets it to 0 on the next edge; clear wins over a simultaneous increment. It resets to 0 on nreset.
- Not defined: neither port exists; no counter logic is synthesised. All other behaviour is identical in both builds.

Test Plan:
- Reset hold: nreset=0 with din toggling, then release at a clk low phase -> q=0, rise=fall=busy=0 throughout, no pulse after release.
- Clean rise (DEBOUNCE=4, en=1): din 0->1 before edge 1 -> busy=1 after edge 3, q=1 and rise=1 after edge 7, rise=0 after edge 8.
- Glitch reject (DEBOUNCE=4): din high for 3 clk then low -> busy pulses, q stays 0, no rise; glitch_cnt=1 when the macro is defined.
- Tick gating (DEBOUNCE=4, en high every 4th cycle): din 1->0 held -> q falls only after the 4th en-tick while in CHECK; fall pulses once.
- Reset mid-CHECK: din 0->1, assert nreset after edge 5 -> q=0, busy=0 immediately; after release with din still 1, rise occurs SYNC_STAGES+1+DEBOUNCE edges later.
- Saturation/clear (macro defined): 300 rejected glitches -> glitch_cnt=255; clr_glitch coincident with a rejection -> glitch_cnt=0.
